// File: rtl/multivar_wait_monitor.sv
// Steps through three signed conditions on a/b/c in order, pulsing cont
// on entry to each wait stage, with optional start delay and stage timeout.
module multivar_wait_monitor #(
  parameter int WIDTH       = 32,
  parameter int START_DELAY = 10,
  parameter int TIMEOUT     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             cont,
  output logic [1:0]       stage,
  output logic             busy,
  output logic             hit,
  output logic             done,
  output logic             timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DELAY,
    S_WAIT0,
    S_WAIT1,
    S_WAIT2,
    S_DONE,
    S_TOUT
  } state_t;

  localparam int CW = 32;
  localparam logic [CW-1:0] DLY_LAST = CW'(START_DELAY - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cont_d, hit_d, busy_d, done_d, to_d;
  logic [1:0]    stage_d;

  logic signed [WIDTH:0] ax, bx, cx, sum;
  logic                  cond0, cond1, cond2, cond_cur;

  // one extra bit keeps a+b exact for any operand pair
  assign ax  = {a[WIDTH-1], a};
  assign bx  = {b[WIDTH-1], b};
  assign cx  = {c[WIDTH-1], c};
  assign sum = ax + bx;

  assign cond0 = $signed(a) > $signed(b);
  assign cond1 = sum < cx;
  assign cond2 = ($signed(a) < $signed(b)) &&
                 ($signed(b) > $signed(c));

  always_comb begin
    cond_cur = 1'b0;
    unique case (state_q)
      S_WAIT0: cond_cur = cond0;
      S_WAIT1: cond_cur = cond1;
      S_WAIT2: cond_cur = cond2;
      default: cond_cur = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cont_d  = 1'b0;
    hit_d   = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE, S_TOUT: begin
        if (start) begin
          cnt_d = '0;
          if (START_DELAY == 0) begin
            state_d = S_WAIT0;
            cont_d  = 1'b1;
          end else begin
            state_d = S_DELAY;
          end
        end
      end
      S_DELAY: begin
        if (cnt_q == DLY_LAST) begin
          state_d = S_WAIT0;
          cnt_d   = '0;
          cont_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT0, S_WAIT1, S_WAIT2: begin
        // a hit on the timeout edge still advances
        if (cond_cur) begin
          hit_d = 1'b1;
          cnt_d = '0;
          unique case (state_q)
            S_WAIT0: state_d = S_WAIT1;
            S_WAIT1: state_d = S_WAIT2;
            default: state_d = S_DONE;
          endcase
          cont_d = (state_q != S_WAIT2);
        end else if (TIMEOUT != 0) begin
          if (cnt_q == TO_LAST) begin
            state_d = S_TOUT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d == S_DELAY) || (state_d == S_WAIT0) ||
             (state_d == S_WAIT1) || (state_d == S_WAIT2);
    done_d = (state_d == S_DONE);
    to_d   = (state_d == S_TOUT);

    stage_d = 2'd0;
    unique case (1'b1)
      state_d == S_WAIT1: stage_d = 2'd1;
      state_d == S_WAIT2: stage_d = 2'd2;
      state_d == S_DONE:  stage_d = 2'd3;
      state_d == S_TOUT:  stage_d = stage;
      default:            stage_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cont    <= 1'b0;
      hit     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      timeout <= 1'b0;
      stage   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cont    <= cont_d;
      hit     <= hit_d;
      busy    <= busy_d;
      done    <= done_d;
      timeout <= to_d;
      stage   <= stage_d;
    end
  end

endmodule

// File: tb/tb_multivar_wait_monitor.sv
// Bench for multivar_wait_monitor: three parameterisations share stimulus and
// are compared every cycle with a stage/age reference model plus directed checks.
module tb_multivar_wait_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] c = '0;

  logic       cont_o  [3];
  logic       busy_o  [3];
  logic       hit_o   [3];
  logic       done_o  [3];
  logic       to_o    [3];
  logic [1:0] stage_o [3];

  int nchk  = 0;
  int nfail = 0;
  int pc0   = 0;
  int ph0   = 0;

  // model: md 0 idle, 1 delay, 2 wait, 3 done, 4 timed out
  int sdp [3] = '{10, 0, 2};
  int top [3] = '{0, 4, 0};
  int wp  [3] = '{32, 32, 8};
  int md  [3];
  int kk  [3];
  int rem [3];
  int age [3];
  bit ec  [3];
  bit eh  [3];

  always #5 clk = ~clk;

  multivar_wait_monitor #(.WIDTH(32), .START_DELAY(10), .TIMEOUT(0)) u_d0 (
    .clk(clk), .rst(rst), .start(start),
    .a(a), .b(b), .c(c),
    .cont(cont_o[0]), .stage(stage_o[0]), .busy(busy_o[0]),
    .hit(hit_o[0]), .done(done_o[0]), .timeout(to_o[0])
  );

  multivar_wait_monitor #(.WIDTH(32), .START_DELAY(0), .TIMEOUT(4)) u_d1 (
    .clk(clk), .rst(rst), .start(start),
    .a(a), .b(b), .c(c),
    .cont(cont_o[1]), .stage(stage_o[1]), .busy(busy_o[1]),
    .hit(hit_o[1]), .done(done_o[1]), .timeout(to_o[1])
  );

  multivar_wait_monitor #(.WIDTH(8), .START_DELAY(2), .TIMEOUT(0)) u_d2 (
    .clk(clk), .rst(rst), .start(start),
    .a(a[7:0]), .b(b[7:0]), .c(c[7:0]),
    .cont(cont_o[2]), .stage(stage_o[2]), .busy(busy_o[2]),
    .hit(hit_o[2]), .done(done_o[2]), .timeout(to_o[2])
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint sx(logic [31:0] v, int w);
    longint t;
    t = longint'(signed'(v));
    t = t <<< (64 - w);
    t = t >>> (64 - w);
    return t;
  endfunction

  function automatic bit condk(int k, longint x, longint y, longint z);
    if (k == 0) return x > y;
    if (k == 1) return (x + y) < z;
    return (x < y) && (y > z);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      md[i] = 0; kk[i] = 0; rem[i] = 0; age[i] = 0;
      ec[i] = 1'b0; eh[i] = 1'b0;
    end
  endtask

  task automatic model_step(int i);
    longint x, y, z;
    x = sx(a, wp[i]);
    y = sx(b, wp[i]);
    z = sx(c, wp[i]);
    ec[i] = 1'b0;
    eh[i] = 1'b0;
    if (md[i] == 2) begin
      if (condk(kk[i], x, y, z)) begin
        eh[i] = 1'b1;
        kk[i]++;
        age[i] = 0;
        if (kk[i] == 3) md[i] = 3;
        else ec[i] = 1'b1;
      end else begin
        age[i]++;
        if (top[i] != 0 && age[i] == top[i]) md[i] = 4;
      end
    end else if (md[i] == 1) begin
      rem[i]--;
      if (rem[i] == 0) begin
        md[i] = 2; kk[i] = 0; age[i] = 0; ec[i] = 1'b1;
      end
    end else if (start) begin
      kk[i] = 0;
      age[i] = 0;
      if (sdp[i] == 0) begin
        md[i] = 2; ec[i] = 1'b1;
      end else begin
        md[i] = 1; rem[i] = sdp[i];
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("d%0d.cont", i), cont_o[i], ec[i]);
      chk($sformatf("d%0d.hit", i), hit_o[i], eh[i]);
      chk($sformatf("d%0d.stage", i), stage_o[i], kk[i]);
      chk($sformatf("d%0d.busy", i), busy_o[i], md[i] == 1 || md[i] == 2);
      chk($sformatf("d%0d.done", i), done_o[i], md[i] == 3);
      chk($sformatf("d%0d.timeout", i), to_o[i], md[i] == 4);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else for (int i = 0; i < 3; i++) model_step(i);
    #1;
    compare_all();
    pc0 += int'(cont_o[0]);
    ph0 += int'(hit_o[0]);
  endtask

  // asynchronous assert mid-cycle; outputs must clear before any edge
  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #2;
    compare_all();
    tick();
    #2;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rnd();
    if ($urandom_range(0, 5) == 0) return $urandom();
    return 32'($urandom_range(0, 16)) - 32'd8;
  endfunction

  initial begin
    model_reset();
    #1;
    do_reset();

    // nominal sequence on d0
    a = 0; b = 0; c = 0;
    pc0 = 0; ph0 = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("nom.busy", busy_o[0], 1);
    chk("nom.cont_early", cont_o[0], 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("nom.cont_at", cont_o[0], i == 9);
    end
    b = 1;
    repeat (5) begin
      tick();
      chk("nom.hold0", stage_o[0], 0);
    end
    a = 2;
    tick();
    chk("nom.hit0", hit_o[0], 1);
    chk("nom.stage1", stage_o[0], 1);
    c = 3;
    repeat (3) begin
      tick();
      chk("nom.hold1", stage_o[0], 1);
    end
    c = 4;
    tick();
    chk("nom.stage2", stage_o[0], 2);
    chk("nom.cont2", cont_o[0], 1);
    b = 5;
    tick();
    chk("nom.done", done_o[0], 1);
    chk("nom.stage3", stage_o[0], 3);
    chk("nom.busy_end", busy_o[0], 0);
    tick();
    chk("nom.ncont", pc0, 3);
    chk("nom.nhit", ph0, 3);
    chk("nom.sticky", done_o[0], 1);

    // immediate fall-through on d1
    do_reset();
    a = 5; b = 0; c = 100;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("fall.cont0", cont_o[1], 1);
    chk("fall.stage0", stage_o[1], 0);
    tick();
    chk("fall.hit0", hit_o[1], 1);
    chk("fall.stage1", stage_o[1], 1);
    tick();
    chk("fall.hit1", hit_o[1], 1);
    chk("fall.stage2", stage_o[1], 2);
    repeat (2) begin
      tick();
      chk("fall.hold2", stage_o[1], 2);
      chk("fall.nodone", done_o[1], 0);
    end
    b = 200;
    tick();
    chk("fall.done", done_o[1], 1);
    chk("fall.stage3", stage_o[1], 3);

    // overflow guard on the 8-bit instance
    do_reset();
    a = 1; b = 0; c = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("ovf.cont0", cont_o[2], 1);
    tick();
    chk("ovf.stage1", stage_o[2], 1);
    a = 127; b = 1; c = 0;
    repeat (3) begin
      tick();
      chk("ovf.hold", stage_o[2], 1);
    end
    a = -100; b = -100; c = -128;
    tick();
    chk("ovf.adv", stage_o[2], 2);
    chk("ovf.cont2", cont_o[2], 1);

    // reset in the middle of WAIT1 on d0
    do_reset();
    a = 1; b = 0; c = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    chk("rst.in_wait1", stage_o[0], 1);
    do_reset();
    chk("rst.busy", busy_o[0], 0);
    chk("rst.stage", stage_o[0], 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rst.replay_cont", cont_o[0], i == 9);
    end

    // start ignored while busy, restart from DONE
    tick();
    chk("ign.stage1", stage_o[0], 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign.stage", stage_o[0], 1);
    chk("ign.busy", busy_o[0], 1);
    chk("ign.cont", cont_o[0], 0);
    c = 5;
    tick();
    chk("ign.stage2", stage_o[0], 2);
    a = 0; b = 2; c = 1;
    tick();
    chk("ign.done", done_o[0], 1);
    start = 1'b1;
    tick();
    chk("re.done_fall", done_o[0], 0);
    chk("re.busy", busy_o[0], 1);
    chk("re.stage", stage_o[0], 0);
    tick();
    start = 1'b0;
    chk("re.held_busy", busy_o[0], 1);

    // timeout on d1
    do_reset();
    a = 0; b = 0; c = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("to.cont", cont_o[1], 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to.early", to_o[1], 0);
      chk("to.busy", busy_o[1], 1);
    end
    tick();
    chk("to.fire", to_o[1], 1);
    chk("to.busy_off", busy_o[1], 0);

    // condition true on the timeout edge wins
    do_reset();
    a = 0; b = 0; c = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    a = 1;
    tick();
    chk("race.hit", hit_o[1], 1);
    chk("race.noto", to_o[1], 0);
    chk("race.stage", stage_o[1], 1);

    // random traffic against the model
    for (int n = 0; n < 600; n++) begin
      start = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 2) == 0) a = rnd();
      if ($urandom_range(0, 2) == 0) b = rnd();
      if ($urandom_range(0, 2) == 0) c = rnd();
      if ($urandom_range(0, 149) == 0) do_reset();
      tick();
    end
    start = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule

// File: doc/multivar_wait_monitor.md
# multivar_wait_monitor

Hardware waiter for the dynamic-scheduler multi-variable wait tests. It steps through three fixed conditions over three signed operands: `a > b`, then `a + b < c`, then `a < b && b > c`. Before waiting on each stage it emits a one-cycle `cont` request to the stimulus side, then holds until the condition is true. It reports progress, completion and an optional per-stage timeout.

## Interface
- `WIDTH`, 32: operand width; operands are signed two's complement.
- `START_DELAY`, 10: cycles spent in DELAY after `start` before stage 0 is armed; 0 skips DELAY.
- `TIMEOUT`, 0: maximum cycles per stage without a hit; 0 disables the timeout.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  level-sampled; begins a run when sampled high in IDLE, DONE or TIMEOUT.
- `a`, `b`, `c`  in  WIDTH each  signed operands, sampled every cycle.
- `cont`  out  1  one-cycle request pulse on the first cycle of each WAIT stage.
- `stage`  out  2  current stage: 0, 1 or 2; reads 3 in DONE.
- `busy`  out  1  high in DELAY and in all WAIT states.
- `hit`  out  1  one-cycle pulse in the cycle after a stage condition is satisfied.
- `done`  out  1  high while in DONE.
- `timeout`  out  1  high while in TIMEOUT.

## Operation
- States: IDLE, DELAY, WAIT0, WAIT1, WAIT2, DONE, TIMEOUT.
- Transitions:
  - IDLE, DONE or TIMEOUT with `start`=1 → DELAY, or → WAIT0 when START_DELAY=0.
  - DELAY counts START_DELAY cycles, then → WAIT0.
  - WAIT0 → WAIT1 → WAIT2 → DONE, each on its condition true at the clock edge.
- Conditions are evaluated combinationally on the current `a`, `b`, `c`:
  - cond0: `a > b`, signed.
  - cond1: `(a + b) < c`, computed at WIDTH+1 bits with sign extension; no wrap-around permitted.
  - cond2: `(a < b) && (b > c)`, signed.
- Conditions are level-sensitive. A condition already true on the first (`cont`) cycle of a stage advances at that edge, so the minimum stage length is 1 cycle.
- Timeout:
  - The per-stage cycle counter clears on stage entry.
  - With TIMEOUT≠0, a stage that reaches TIMEOUT cycles without a hit → TIMEOUT.
  - If the condition and the timeout occur at the same edge, the condition wins.
- DONE and TIMEOUT are sticky until `start` or `rst`.
- `start` is ignored while `busy`.
- Outputs `cont`, `hit`, `stage`, `busy`, `done` and `timeout` are registered (derived from next-state).

## Timing
- Reset values: state IDLE, `cont`=0, `stage`=0, `busy`=0, `hit`=0, `done`=0, `timeout`=0; counters cleared.
- Reset asserted mid-run aborts immediately (asynchronous), with no `cont` or `hit` pulse. Operation resumes only on a new `start` after `rst` deasserts.
- `start` sampled at edge N:
  - `busy`=1 from N+1.
  - `cont` for stage 0 is high in the cycle after edge N+START_DELAY (edge N when START_DELAY=0).
- Condition k true at edge M:
  - At M: `hit`=1 for one cycle, `stage`=k+1, and `cont`=1 for one cycle (`cont` only if k<2).
  - For k=2: `done`=1 and `busy`=0 at M.
- Timeout: entering a stage at edge E with no hit → `timeout`=1 and `busy`=0 at edge E+TIMEOUT.
- Back-to-back runs: `start` held high in DONE restarts at the next edge. `done` drops at that same edge.

## Test plan
- Nominal sequence, START_DELAY=10, TIMEOUT=0. Start with a=b=c=0.
  - `cont` appears 10 cycles after `start`.
  - Drive b=1, wait 5 cycles, drive a=2 → `hit` and stage 1 one edge later.
  - Drive c=3 → no advance, since 3<3 is false.
  - Drive c=4 → stage 2 and `cont`.
  - Drive b=5 → `done`=1, `stage`=3. Exactly 3 `cont` and 3 `hit` pulses in total.
- Immediate fall-through: a=5, b=0, c=100 held constant, START_DELAY=0.
  - Stages 0 and 1 each last exactly 1 cycle.
  - Stage 2 holds because 5<0 is false.
  - Then set b=200 → `done`.
- Overflow guard, WIDTH=8: a=127, b=1, c=0 in stage 1.
  - Must not advance: the true sum is 128, not <0; a wrapped sum of -128 would wrongly pass.
  - Then c=-128, a=-100, b=-100 → advances (-200 < -128).
- Timeout, TIMEOUT=4: hold a=b in stage 0.
  - `timeout`=1 exactly 4 edges after stage entry; `busy`=0.
  - Same setup with a>b set on the 4th cycle → hit wins, no `timeout`.
- Reset mid-operation: assert `rst` asynchronously during WAIT1.
  - All outputs read reset values before the next clock edge.
  - A new `start` replays from DELAY with a fresh `cont` sequence.
- Restart and `start` ignore:
  - `start` pulsed during WAIT1 → no effect.
  - `start` held high in DONE → new run begins next edge; `done` falls on that edge.
